// File: rtl/uart_tx_serializer.sv
// Purpose: 8N1/8N2 UART transmitter fed by a single-cycle (tx_byte, transmit) strobe.
// Latency: tx drops to the start bit on the acceptance edge; a frame lasts (9+NSTOP)*CLKS_PER_BIT cycles.
// Backpressure: is_transmitting is high while busy; strobes arriving while busy are dropped and set sticky overrun.
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 868,
   parameter int NSTOP        = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       transmit,
   input  logic [7:0] tx_byte,
   output logic       is_transmitting,
   output logic       tx,
   output logic       overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int SW = $clog2(NSTOP + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [SW-1:0] STOP_LAST = SW'(NSTOP - 1);

   logic [1:0]    state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic [SW-1:0] stop_cnt;
   logic          bit_end;

   // A bit period ends on the last count of the baud counter.
   assign bit_end = (baud_cnt == BAUD_LAST);

   // Frame sequencer: tx and busy are driven from registers, one step ahead of the state they describe.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state           <= S_IDLE;
         baud_cnt        <= '0;
         bit_idx         <= '0;
         shift           <= '0;
         stop_cnt        <= '0;
         tx              <= 1'b1;
         is_transmitting <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (transmit) begin
                  shift           <= tx_byte;
                  baud_cnt        <= '0;
                  state           <= S_START;
                  tx              <= 1'b0;
                  is_transmitting <= 1'b1;
               end
            end
            S_START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= S_DATA;
                  tx       <= shift[0];
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  shift    <= {1'b0, shift[7:1]};
                  bit_idx  <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state    <= S_STOP;
                     stop_cnt <= '0;
                     tx       <= 1'b1;
                  end else begin
                     // Next data bit is the one about to reach shift[0].
                     tx <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (stop_cnt == STOP_LAST) begin
                     state           <= S_IDLE;
                     is_transmitting <= 1'b0;
                  end else begin
                     stop_cnt <= stop_cnt + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state           <= S_IDLE;
               tx              <= 1'b1;
               is_transmitting <= 1'b0;
            end
         endcase
      end
   end

   // Sticky overrun: any strobe outside IDLE (including the final STOP edge) is a dropped byte.
   always_ff @(posedge clk) begin
      if (!rst) begin
         overrun <= 1'b0;
      end else if (transmit && (state != S_IDLE)) begin
         overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Purpose: bench for uart_tx_serializer with one-stop and two-stop instances sharing one stimulus stream.
// Latency: model predicts the line level as frame_bits[cycles_since_acceptance / CLKS_PER_BIT].
// Backpressure: model flags overrun on any strobe while a frame is still counting down.
module tb_uart_tx_serializer;

   localparam int C = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       transmit = 1'b0;
   logic [7:0] tx_byte = 8'h00;
   logic       busy1, tx1, ovr1;
   logic       busy2, tx2, ovr2;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   uart_tx_serializer #(.CLKS_PER_BIT(C), .NSTOP(1)) dut1 (
      .clk(clk), .rst(rst), .transmit(transmit), .tx_byte(tx_byte),
      .is_transmitting(busy1), .tx(tx1), .overrun(ovr1));

   uart_tx_serializer #(.CLKS_PER_BIT(C), .NSTOP(2)) dut2 (
      .clk(clk), .rst(rst), .transmit(transmit), .tx_byte(tx_byte),
      .is_transmitting(busy2), .tx(tx2), .overrun(ovr2));

   always #5 clk = ~clk;

   // Reference model: a frame is an 11-entry bit list (start, 8 data LSB first, stop bits)
   // played out for len cycles from the acceptance edge.
   bit          m_act [2];
   int          m_el  [2];
   bit          m_ovr [2];
   logic [10:0] m_bits[2];
   int          m_len [2] = '{10 * C, 11 * C};

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst) begin
            m_act[i] = 1'b0;
            m_el[i]  = 0;
            m_ovr[i] = 1'b0;
         end else if (m_act[i]) begin
            if (transmit) m_ovr[i] = 1'b1;
            m_el[i] = m_el[i] + 1;
            if (m_el[i] == m_len[i]) m_act[i] = 1'b0;
         end else if (transmit) begin
            m_act[i]  = 1'b1;
            m_el[i]   = 0;
            m_bits[i] = {2'b11, tx_byte, 1'b0};
         end
      end
   end

   function automatic logic model_tx(input int i);
      return m_act[i] ? m_bits[i][m_el[i] / C] : 1'b1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of both instances against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("tx1",   {31'd0, tx1},   {31'd0, model_tx(0)});
         chk("busy1", {31'd0, busy1}, {31'd0, m_act[0]});
         chk("ovr1",  {31'd0, ovr1},  {31'd0, m_ovr[0]});
         chk("tx2",   {31'd0, tx2},   {31'd0, model_tx(1)});
         chk("busy2", {31'd0, busy2}, {31'd0, m_act[1]});
         chk("ovr2",  {31'd0, ovr2},  {31'd0, m_ovr[1]});
      end
   end

   task automatic pulse(input logic [7:0] b);
      tx_byte  = b;
      transmit = 1'b1;
      @(negedge clk);
      transmit = 1'b0;
   endtask

   task automatic do_reset();
      transmit = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Starts one cycle after acceptance; samples the one-stop line mid-bit and returns when it is idle again.
   task automatic run_frame(input int inj_k, input logic [7:0] inj_b, output logic [7:0] d);
      d = '0;
      for (int k = 0; k < 10 * C; k++) begin
         if (k == inj_k) begin
            tx_byte  = inj_b;
            transmit = 1'b1;
         end else begin
            transmit = 1'b0;
         end
         if ((k % C) == (C / 2) && (k / C) >= 1 && (k / C) <= 8) d[k / C - 1] = tx1;
         @(negedge clk);
      end
      transmit = 1'b0;
   endtask

   initial begin
      logic [9:0] exp_a5;
      logic [7:0] d;
      int         hold;
      exp_a5 = 10'b1101001010;

      // Reset held with transmit asserted.
      rst = 1'b0;
      transmit = 1'b1;
      tx_byte = 8'hC3;
      @(negedge clk);
      chk_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_tx",   {31'd0, tx1},   32'd1);
         chk("rst_busy", {31'd0, busy1}, 32'd0);
         chk("rst_ovr",  {31'd0, ovr1},  32'd0);
         @(negedge clk);
      end
      rst = 1'b1;
      transmit = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_rst_busy", {31'd0, busy1}, 32'd0);
      chk("post_rst_tx",   {31'd0, tx2},   32'd1);

      // Single byte 0xA5 on both instances.
      pulse(8'hA5);
      for (int k = 0; k <= 44; k++) begin
         if ((k % C) == 0 && k < 40) chk("a5_bit", {31'd0, tx1}, {31'd0, exp_a5[k / C]});
         if (k == 39) chk("a5_busy_last", {31'd0, busy1}, 32'd1);
         if (k == 40) chk("a5_busy_fall", {31'd0, busy1}, 32'd0);
         if (k == 36 || k == 43) chk("n2_stop_high", {31'd0, tx2}, 32'd1);
         if (k == 43) chk("n2_busy_last", {31'd0, busy2}, 32'd1);
         if (k == 44) chk("n2_busy_fall", {31'd0, busy2}, 32'd0);
         @(negedge clk);
      end

      // Back-to-back 0x00 then 0xFF, second strobe on the first idle cycle.
      do_reset();
      pulse(8'h00);
      run_frame(-1, 8'h00, d);
      chk("b2b_first", {24'd0, d}, 32'h00);
      chk("b2b_idle", {31'd0, busy1}, 32'd0);
      pulse(8'hFF);
      chk("b2b_start", {31'd0, tx1}, 32'd0);
      chk("b2b_busy", {31'd0, busy1}, 32'd1);
      run_frame(-1, 8'h00, d);
      chk("b2b_second", {24'd0, d}, 32'hFF);
      chk("b2b_no_ovr", {31'd0, ovr1}, 32'd0);

      // Overrun: 0x99 pushed mid-DATA of 0x3C.
      do_reset();
      pulse(8'h3C);
      run_frame(18, 8'h99, d);
      chk("ovr_line", {24'd0, d}, 32'h3C);
      chk("ovr_set", {31'd0, ovr1}, 32'd1);
      repeat (10) @(negedge clk);
      chk("ovr_sticky", {31'd0, ovr1}, 32'd1);
      chk("ovr_idle", {31'd0, busy1}, 32'd0);

      // Mid-frame reset during data bit 3 of 0x52.
      do_reset();
      pulse(8'h52);
      repeat (17) @(negedge clk);
      chk("mid_bit3", {31'd0, tx1}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_tx", {31'd0, tx1}, 32'd1);
      chk("mid_rst_busy", {31'd0, busy1}, 32'd0);
      chk("mid_rst_busy2", {31'd0, busy2}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_idle_tx", {31'd0, tx1}, 32'd1);
      pulse(8'h81);
      chk("mid_new_start", {31'd0, tx1}, 32'd0);
      run_frame(-1, 8'h00, d);
      chk("mid_new_byte", {24'd0, d}, 32'h81);

      // Randomized traffic: idle-time strobes, busy strobes, held strobes, occasional resets.
      do_reset();
      hold = 0;
      for (int n = 0; n < 3000; n++) begin
         tx_byte = 8'($urandom);
         if (hold > 0) begin
            transmit = 1'b1;
            hold--;
         end else if (!busy1 && $urandom_range(0, 3) == 0) begin
            transmit = 1'b1;
         end else if ($urandom_range(0, 99) == 0) begin
            transmit = 1'b1;
            hold = $urandom_range(1, 3);
         end else begin
            transmit = ($urandom_range(0, 59) == 0);
         end
         rst = ($urandom_range(0, 499) != 0);
         @(negedge clk);
      end
      transmit = 1'b0;
      rst = 1'b1;
      repeat (50) @(negedge clk);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
